// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared types and vector addresses for the memory port arbiter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_VEC   = 2'd3
  } owner_e;

  localparam logic RESET_VEC = 1'b0;
  localparam logic INTR_VEC  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if                                                  |
// | Requester, memory and status signals of the shared memory port.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_done;
  logic          fetch_stall;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_gnt;
  logic          data_done;
  logic          vec_req;
  logic          vec_sel;
  logic          vec_gnt;
  logic          vec_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rdata;
  logic          busy;

  modport arb (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           vec_req, vec_sel, mem_rdata,
    output fetch_gnt, fetch_done, fetch_stall, data_gnt, data_done,
           vec_gnt, vec_done, mem_addr, mem_wdata, mem_re, mem_we, rdata, busy
  );

  modport client (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           vec_req, vec_sel, mem_rdata,
    input  fetch_gnt, fetch_done, fetch_stall, data_gnt, data_done,
           vec_gnt, vec_done, mem_addr, mem_wdata, mem_re, mem_we, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pick                                                         |
// | Combinational requester selection: vec > data > fetch, with fetch    |
// | promoted over data once data has starved it.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  wire    i_vec_req,
  input  wire    i_data_req,
  input  wire    i_fetch_req,
  input  wire    i_starved,
  output owner_e o_pick
);

  always_comb begin
    o_pick = OWN_NONE;
    if (i_vec_req)
      o_pick = OWN_VEC;
    else if (i_data_req && !(i_fetch_req && i_starved))
      o_pick = OWN_DATA;
    else if (i_fetch_req)
      o_pick = OWN_FETCH;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Single-port memory arbiter for fetch, data and vector requesters.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input wire               clk,
  input wire               reset_n,
  mem_port_arbiter_if.arb  bus
);

  localparam int c_LW = $clog2(MEM_LAT) + 1;
  localparam int c_SW = $clog2(STARVE_MAX + 1) + 1;
  localparam logic [c_LW-1:0] c_LAT_LAST   = c_LW'(MEM_LAT - 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

  state_e          r_state;
  owner_e          r_owner;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_we;
  logic [c_LW-1:0] r_lat_cnt;
  logic [c_SW-1:0] r_starve_cnt;
  logic [DW-1:0]   r_rdata;

  owner_e w_pick;
  owner_e w_grant;
  owner_e w_done;
  logic   w_last;
  logic   w_busy;

  mem_arb_pick u_pick (
    .i_vec_req   (bus.vec_req),
    .i_data_req  (bus.data_req),
    .i_fetch_req (bus.fetch_req),
    .i_starved   (r_starve_cnt == c_STARVE_MAX),
    .o_pick      (w_pick)
  );

  // Grants are combinational from the requests, so they are masked during reset.
  assign w_busy  = (r_state == ST_BUSY);
  assign w_grant = (reset_n && !w_busy) ? w_pick : OWN_NONE;
  assign w_last  = w_busy && (r_lat_cnt == c_LAT_LAST);
  assign w_done  = w_last ? r_owner : OWN_NONE;

  assign bus.fetch_gnt   = (w_grant == OWN_FETCH);
  assign bus.data_gnt    = (w_grant == OWN_DATA);
  assign bus.vec_gnt     = (w_grant == OWN_VEC);
  assign bus.fetch_done  = (w_done == OWN_FETCH);
  assign bus.data_done   = (w_done == OWN_DATA);
  assign bus.vec_done    = (w_done == OWN_VEC);
  assign bus.fetch_stall = reset_n && !bus.fetch_done &&
                           (bus.fetch_req || (w_busy && r_owner == OWN_FETCH));
  assign bus.busy        = w_busy;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.mem_re      = w_busy && !r_we;
  assign bus.mem_we      = w_busy && r_we && (r_lat_cnt == '0);
  assign bus.rdata       = (w_done != OWN_NONE) ? bus.mem_rdata : r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick != OWN_NONE) begin
            r_state   <= ST_BUSY;
            r_owner   <= w_pick;
            r_lat_cnt <= '0;
            r_we      <= 1'b0;
            case (w_pick)
              OWN_VEC:   r_addr <= AW'(bus.vec_sel ? INTR_VEC : RESET_VEC);
              OWN_DATA: begin
                r_addr  <= bus.data_addr;
                r_wdata <= bus.data_wdata;
                r_we    <= bus.data_we;
              end
              OWN_FETCH: r_addr <= bus.fetch_addr;
              default: ;
            endcase
            if (w_pick == OWN_FETCH)
              r_starve_cnt <= '0;
            else if (w_pick == OWN_DATA && bus.fetch_req && r_starve_cnt != c_STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_rdata <= bus.mem_rdata;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                  |
// | Directed scoreboard bench for mem_port_arbiter (MEM_LAT=2, STARVE=3).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct {
    logic [2:0] who;     // {vec, data, fetch}
    logic [7:0] rd;
    logic       chk_rd;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [7:0] mem   [256];
  logic       mem_v [256];

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations read as addr ^ 0xA5.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem_v[i] <= 1'b0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr]   <= bus.mem_wdata;
      mem_v[bus.mem_addr] <= 1'b1;
    end
  end
  assign bus.mem_rdata = mem_v[bus.mem_addr] ? mem[bus.mem_addr] : (bus.mem_addr ^ 8'hA5);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_gnt(input string name, input logic [2:0] req);
    chk(name, {29'd0, bus.vec_gnt, bus.data_gnt, bus.fetch_gnt}, {29'd0, req});
  endtask

  task automatic push(input logic [2:0] who, input logic [7:0] rd, input logic chk_rd, input int c);
    exp_t e;
    e.who = who; e.rd = rd; e.chk_rd = chk_rd; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [2:0] d;
    exp_t       e;
    d = {bus.vec_done, bus.data_done, bus.fetch_done};
    if (d != 3'b000) begin
      if (q.size() == 0) begin
        chk("done_unexpected", {29'd0, d}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_owner", {29'd0, d}, {29'd0, e.who});
        chk("done_cycle", cyc, e.cyc);
        if (e.chk_rd) chk("done_rdata", {24'd0, bus.rdata}, {24'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    int         nwe;
    logic [2:0] seq [5];
    checks = 0; errors = 0;
    reset_n = 1'b0;
    bus.fetch_req = 0; bus.fetch_addr = 0; bus.data_req = 0; bus.data_we = 0;
    bus.data_addr = 0; bus.data_wdata = 0; bus.vec_req = 0; bus.vec_sel = 0;
    repeat (3) step();

    // Reset: requests must not leak through.
    bus.fetch_req = 1; bus.fetch_addr = 8'h10; #1;
    chk_gnt("rst_gnt", 3'b000);
    chk("rst_stall", bus.fetch_stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_rdata", bus.rdata, 0);
    bus.fetch_req = 0;
    reset_n = 1'b1;
    step();

    // Lone fetch of 0x10.
    bus.fetch_req = 1; bus.fetch_addr = 8'h10; #1;
    t = cyc;
    chk_gnt("f_gnt", 3'b001);
    chk("f_stall_c0", bus.fetch_stall, 1);
    push(3'b001, 8'hB5, 1'b1, t + 2);
    step(); bus.fetch_req = 0; #1;
    chk("f_re_c1", bus.mem_re, 1);
    chk("f_stall_c1", bus.fetch_stall, 1);
    step();
    chk("f_re_c2", bus.mem_re, 1);
    chk("f_stall_c2", bus.fetch_stall, 0);
    step();
    chk("f_re_c3", bus.mem_re, 0);
    chk("f_busy_c3", bus.busy, 0);
    chk("f_rdata_hold", bus.rdata, 8'hB5);

    // All three requesters at once.
    bus.vec_req = 1; bus.vec_sel = 1;
    bus.data_req = 1; bus.data_we = 0; bus.data_addr = 8'h30;
    bus.fetch_req = 1; bus.fetch_addr = 8'h40; #1;
    t = cyc;
    chk_gnt("all_vec_gnt", 3'b100);
    push(3'b100, 8'hA4, 1'b1, t + 2);
    step(); bus.vec_req = 0; #1;
    chk("all_vec_addr", bus.mem_addr, 8'h01);
    chk_gnt("all_no_preempt", 3'b000);
    step(); step();
    chk_gnt("all_data_gnt", 3'b010);
    push(3'b010, 8'h95, 1'b1, t + 5);
    step(); bus.data_req = 0;
    step(); step();
    chk_gnt("all_fetch_gnt", 3'b001);
    push(3'b001, 8'hE5, 1'b1, t + 8);
    step(); bus.fetch_req = 0;
    step(); step();

    // Data writes starving fetch.
    seq[0] = 3'b010; seq[1] = 3'b010; seq[2] = 3'b010; seq[3] = 3'b001; seq[4] = 3'b010;
    bus.data_req = 1; bus.data_we = 1; bus.fetch_req = 1; bus.fetch_addr = 8'h11;
    nwe = 0;
    for (int k = 0; k < 5; k++) begin
      bus.data_addr = 8'h50 + nwe[7:0]; bus.data_wdata = 8'h60 + nwe[7:0]; #1;
      t = cyc;
      chk_gnt($sformatf("starve_gnt%0d", k), seq[k]);
      if (seq[k] == 3'b010) begin
        push(3'b010, 8'h00, 1'b0, t + 2);
        nwe++;
      end else begin
        push(3'b001, 8'hB4, 1'b1, t + 2);
      end
      step();
      if (k == 2) chk("starve_sat", {30'd0, dut.r_starve_cnt}, 3);
      if (k == 3) begin
        chk("starve_clr", {30'd0, dut.r_starve_cnt}, 0);
        bus.fetch_req = 0;
      end
      if (k == 4) bus.data_req = 0;
      step(); step();
    end
    chk("starve_end", {30'd0, dut.r_starve_cnt}, 0);

    // Single write pulse and readback.
    bus.data_req = 1; bus.data_we = 1; bus.data_addr = 8'h20; bus.data_wdata = 8'h5A; #1;
    t = cyc;
    chk_gnt("wr_gnt", 3'b010);
    push(3'b010, 8'h00, 1'b0, t + 2);
    nwe = 0;
    step(); bus.data_req = 0; #1;
    nwe += int'(bus.mem_we);
    step(); nwe += int'(bus.mem_we);
    step(); nwe += int'(bus.mem_we);
    chk("wr_we_pulses", nwe, 1);
    bus.data_req = 1; bus.data_we = 0; #1;
    t = cyc;
    chk_gnt("rb_gnt", 3'b010);
    push(3'b010, 8'h5A, 1'b1, t + 2);
    step(); bus.data_req = 0;
    step(); step();

    // Reset during a fetch in flight.
    bus.fetch_req = 1; bus.fetch_addr = 8'h70; #1;
    chk_gnt("abort_gnt", 3'b001);
    step();
    reset_n = 1'b0; #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_re", bus.mem_re, 0);
    chk("abort_we", bus.mem_we, 0);
    chk("abort_stall", bus.fetch_stall, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_rdata", bus.rdata, 0);
    chk_gnt("abort_gnt_rst", 3'b000);
    step(); step();
    reset_n = 1'b1; #1;
    t = cyc;
    chk("abort_idle", bus.busy, 0);
    chk_gnt("abort_regnt", 3'b001);
    push(3'b001, 8'hD5, 1'b1, t + 2);
    step(); bus.fetch_req = 0;
    repeat (3) step();

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be:
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 2, memory access cycles (>=1)
- STARVE_MAX, 3, consecutive data grants before fetch is forced
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- fetch_req  in  1  instruction read request
- fetch_addr  in  AW  instruction address
- fetch_gnt  out  1  fetch granted
- fetch_done  out  1  fetch read complete, rdata valid
- fetch_stall  out  1  fetch stage must hold PC
- data_req  in  1  memory-stage request
- data_we  in  1  1=write, 0=read
- data_addr  in  AW  data address
- data_wdata  in  DW  write data
- data_gnt  out  1  data granted
- data_done  out  1  data access complete
- vec_req  in  1  reset/interrupt vector read
- vec_sel  in  1  0=M[0] reset, 1=M[1] interrupt
- vec_gnt  out  1  vector granted
- vec_done  out  1  vector read complete
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data
- rdata  out  DW  read data to the current owner
- busy  out  1  access in flight

Function
REQ-004 The FSM SHALL have two states, IDLE and BUSY, plus an owner register (NONE/FETCH/DATA/VEC).
REQ-005 In IDLE, if any request is high, the block SHALL grant one requester in that same cycle, combinationally:
- Priority: vec > data > fetch.
- Override: fetch beats data when starve_cnt==STARVE_MAX.
REQ-006 The grant cycle SHALL:
- Register owner, address, wdata and we.
- Use address vec_sel (zero-extended) for a vector grant.
- Go to BUSY with lat_cnt=0.
REQ-007 In BUSY, the block SHALL:
- Drive mem_addr and mem_wdata from the latched values.
- Hold mem_re high for every cycle of a read.
- Pulse mem_we only in the first BUSY cycle of a write.
REQ-008 lat_cnt SHALL increment each BUSY cycle; at lat_cnt==MEM_LAT-1 the owner's done SHALL pulse for one cycle, rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE.
REQ-009 Latency SHALL be: request seen at cycle t, grant at t, done at t+MEM_LAT, next grant possible at t+MEM_LAT+1.
REQ-010 Requests are level signals; a requester SHALL drop req by its done cycle, and any req high in IDLE is a new request.
REQ-011 Once BUSY, the block SHALL NOT preempt the owner; a vec_req arriving during BUSY waits for IDLE.
REQ-012 fetch_stall SHALL be high when (fetch_req high or fetch in flight) and fetch_done is low.
REQ-013 starve_cnt SHALL:
- Increment, saturating at STARVE_MAX, on each data grant while fetch_req is high.
- Clear on any fetch grant.
- Hold otherwise.
REQ-014 busy SHALL equal (state==BUSY).
REQ-015 For all outputs outside an access: gnt and done SHALL be zero, mem_re and mem_we zero, rdata held at the last captured value.

Reset
REQ-016 While reset_n is low, the block SHALL force:
- State IDLE, owner NONE.
- lat_cnt and starve_cnt = 0.
- All gnt, done, stall, mem_re and mem_we outputs = 0.
- mem_addr, mem_wdata and rdata = 0.
REQ-017 Reset asserted mid-BUSY SHALL abort the access with no done pulse and no further mem_we.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state enum, the owner encoding, and RESET_VEC=0 and INTR_VEC=1.
REQ-019 The priority/starvation selection SHALL be a combinational sub-module mem_arb_pick.

Verification (MEM_LAT=2, STARVE_MAX=3)
REQ-020 Lone fetch_req, addr 0x10 at cycle 0 -> fetch_gnt at 0, mem_re at 1-2, fetch_done and rdata=M[0x10] at 2, fetch_stall low at 2.
REQ-021 vec_req (sel=1), data_req and fetch_req all high at cycle 0 -> vec_gnt, mem_addr=0x01, vec_done at 2; data_gnt at 3.
REQ-022 data_req held for 4 back-to-back writes with fetch_req high -> data, data, data, then fetch granted; starve_cnt returns to 0.
REQ-023 Data write 0x5A to 0x20 -> mem_we high for exactly 1 cycle, data_done at grant+2; a readback returns 0x5A.
REQ-024 reset_n low at BUSY cycle 1 of a fetch -> no fetch_done, all outputs 0; after release, IDLE and a new grant on the next request.
